// File: rtl/qubit_measure.sv
// qubit_measure
// Readout unit for a single real-amplitude qubit state (alpha, beta) in Q16.16.
// It squares both amplitudes, draws a 16-bit pseudo-random sample r, scales r
// by the norm alpha^2 + beta^2 and compares the result against alpha^2.
// It then returns the measured bit and the collapsed basis state.
// One shared signed 32x32 multiplier is time-multiplexed across a six-state FSM:
//   IDLE -> SQ_A -> SQ_B -> SCALE -> DECIDE -> DONE -> IDLE
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (ready only in IDLE)
//   alpha_in, beta_in     signed Q16.16 amplitudes
//   out_valid / out_ready result handshake (valid only in DONE)
//   outcome               measured bit
//   prob0                 alpha^2 in Q16.16, unnormalised
//   alpha_out, beta_out   collapsed state, |0> = (1,0), |1> = (0,1)
//   err                   zero norm or arithmetic overflow (forces |0>)
//   count0, count1        only with QMEAS_STATS_EN: saturating result counters
//
// Optional feature macro: QMEAS_STATS_EN
module qubit_measure #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [31:0] ONE_Q16   = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alpha_in,
  input  logic [31:0] beta_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        outcome,
  output logic [31:0] prob0,
  output logic [31:0] alpha_out,
  output logic [31:0] beta_out,
`ifdef QMEAS_STATS_EN
  output logic [15:0] count0,
  output logic [15:0] count1,
`endif
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SQ_A   = 3'd1,
    SQ_B   = 3'd2,
    SCALE  = 3'd3,
    DECIDE = 3'd4,
    DONE   = 3'd5
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  state_t state_q, state_d;

  logic [31:0] alpha_q, beta_q;
  logic [15:0] r_q, lfsr_q, lfsr_next;
  logic [31:0] p0_q, p1_q, scaled_q;
  logic        ovf_q;

  logic        accept;
  logic        handshake;
  logic signed [31:0] mul_a, mul_b;
  logic signed [63:0] mul_full;
  logic [31:0] mul_res;
  logic        mul_ovf;
  logic [31:0] norm;
  logic        norm_ovf;
  logic        err_d, outcome_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // Galois step: shift right, apply the tap mask when a 1 falls out.
  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

  // Norm is formed from the registered squares; it is valid in SCALE and DECIDE.
  assign norm     = p0_q + p1_q;
  assign norm_ovf = (p0_q[31] == p1_q[31]) && (norm[31] != p0_q[31]);

  // Shared multiplier operand select.
  // NOTE: every signal written in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      SQ_A: begin
        mul_a = alpha_q;
        mul_b = alpha_q;
      end
      SQ_B: begin
        mul_a = beta_q;
        mul_b = beta_q;
      end
      SCALE: begin
        mul_a = {16'b0, r_q};
        mul_b = norm;
      end
      default: ;
    endcase
  end

  assign mul_full = mul_a * mul_b;
  assign mul_res  = mul_full[47:16];
  // The shifted result fits in 32 signed bits only if bits [63:47] are a pure sign extension.
  assign mul_ovf  = !((&mul_full[63:47]) || (~|mul_full[63:47]));

  // Final decision from the registered intermediate values.
  assign err_d     = ovf_q || (norm == 32'h0);
  assign outcome_d = !err_d && ($signed(scaled_q) >= $signed(p0_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SQ_A;
      SQ_A:    state_d = SQ_B;
      SQ_B:    state_d = SCALE;
      SCALE:   state_d = DECIDE;
      DECIDE:  state_d = DONE;
      DONE:    if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers. All of them are plain flops, so all are reset; an
  // aborted measurement leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alpha_q  <= '0;
      beta_q   <= '0;
      r_q      <= '0;
      lfsr_q   <= SEED;
      p0_q     <= '0;
      p1_q     <= '0;
      scaled_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alpha_q <= alpha_in;
            beta_q  <= beta_in;
            r_q     <= lfsr_q;
            lfsr_q  <= lfsr_next;
            ovf_q   <= 1'b0;
          end
        end
        SQ_A: begin
          p0_q  <= mul_res;
          ovf_q <= ovf_q | mul_ovf;
        end
        SQ_B: begin
          p1_q  <= mul_res;
          ovf_q <= ovf_q | mul_ovf;
        end
        SCALE: begin
          scaled_q <= mul_res;
          ovf_q    <= ovf_q | mul_ovf | norm_ovf;
        end
        default: ;
      endcase
    end
  end

  // Result registers load only on the DECIDE -> DONE transition and otherwise
  // hold, so the last result stays visible in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outcome   <= 1'b0;
      err       <= 1'b0;
      prob0     <= '0;
      alpha_out <= '0;
      beta_out  <= '0;
    end else if (state_q == DECIDE) begin
      outcome   <= outcome_d;
      err       <= err_d;
      prob0     <= p0_q;
      alpha_out <= outcome_d ? 32'h0 : ONE_Q16;
      beta_out  <= outcome_d ? ONE_Q16 : 32'h0;
    end
  end

`ifdef QMEAS_STATS_EN
  // Saturating outcome counters, bumped on each accepted result that is not an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count0 <= '0;
      count1 <= '0;
    end else if (handshake && !err) begin
      if (outcome) begin
        if (count1 != 16'hFFFF) count1 <= count1 + 16'd1;
      end else begin
        if (count0 != 16'hFFFF) count0 <= count0 + 16'd1;
      end
    end
  end
`endif

endmodule
